mult_seq: RTL

- Multi-cycle radix-2 shift-add multiplier for the CPU54 MULT/MULTU path; it is the multiply counterpart of the sequential unsigned divider.
- Uses the same start/busy handshake as the divider, so the mult/div control stage drives both units identically.
- Produces a 2*WIDTH-bit product split into HI/LO.
- Supports signed mode: operands are converted to magnitudes, multiplied unsigned, and the product is negated once at the end if needed.

---
 rtl/mul_div_pkg.sv | 18 +
 rtl/twos_abs.sv | 15 +
 rtl/mult_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide units.
package mul_div_pkg;

   localparam int DEF_WIDTH = 32;

   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int CNT_W = cnt_w(DEF_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/twos_abs.sv
// Magnitude and sign of a two's-complement value; the most negative value maps to itself as unsigned.
module twos_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] mag,
   output logic             sign
);

   always_comb begin
      sign = x[WIDTH-1];
      mag  = sign ? (~x + WIDTH'(1)) : x;
   end

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier, fixed WIDTH+1 cycle latency, HI/LO product with optional signed mode.
// Handshake: start is sampled only while idle; busy is high from the accepting edge until the
// edge that loads hi/lo, where done pulses for one cycle. A start during busy is dropped.
module mult_seq
   import mul_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output state_e           dbg_state
);

   localparam int CW = cnt_w(WIDTH);

   state_e             state, state_nxt;
   logic [WIDTH-1:0]   mcand, mplier;
   logic [WIDTH:0]     acc, sum;
   logic [CW-1:0]      count;
   logic               neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               sign_a, sign_b;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic               last_iter;

   twos_abs #(.WIDTH(WIDTH)) u_abs_a (.x(a), .mag(mag_a), .sign(sign_a));
   twos_abs #(.WIDTH(WIDTH)) u_abs_b (.x(b), .mag(mag_b), .sign(sign_b));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   assign last_iter = (count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      dbg_state = state;
   end

   always_comb begin
      sum      = acc + (mplier[0] ? {1'b0, mcand} : '0);
      prod     = {acc[WIDTH-1:0], mplier};
      prod_fix = neg ? (~prod + (2*WIDTH)'(1)) : prod;
   end

   // hi/lo only change in FIX so a read during busy sees the previous product.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: if (start) begin
               mcand  <= is_signed ? mag_a : a;
               mplier <= is_signed ? mag_b : b;
               neg    <= is_signed & (sign_a ^ sign_b);
               acc    <= '0;
               count  <= '0;
            end
            CALC: begin
               acc    <= {1'b0, sum[WIDTH:1]};
               mplier <= {sum[0], mplier[WIDTH-1:1]};
               count  <= count + CW'(1);
            end
            FIX: begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule
